// File: rtl/ram_dma_copier.sv
// ---------------------------------------------------------------------------
// ram_dma_copier
//
// Word-granular memory-to-memory copy engine. It drives one port of a
// byte-addressed RAM that has a registered (one-cycle) read. Software
// programs a source, a destination and a length in 32-bit words, then pulses
// start_i. The engine alternates a READ cycle and a WRITE cycle for each word
// and copies in strictly ascending address order. When the destination
// region overlaps the source region with dst > src, the result is what a
// forward word-by-word copy produces.
//
// Optional build macro: DMA_FILL_EN
//   When this macro is defined, the block gains the inputs fill_i and
//   pattern_i. With fill_i=1 the engine skips the READ cycles and writes
//   pattern_i to every destination word, at one word per cycle. In fill mode
//   src_i is ignored and is not checked. When the macro is not defined, only
//   copy mode exists.
//
// Ports
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   start_i     one-cycle start request, sampled only in IDLE
//   src_i       source byte address (must be word aligned)
//   dst_i       destination byte address (must be word aligned)
//   len_i       transfer length in 32-bit words
//   fill_i      (DMA_FILL_EN only) select fill mode, latched at start
//   pattern_i   (DMA_FILL_EN only) fill word, latched at start
//   busy_o      high from the cycle after an accepted start until DONE ends
//   done_o      one-cycle pulse on completion, including len=0
//   err_o       one-cycle pulse when a start is rejected
//   mem_en_o    RAM port enable
//   mem_we_o    RAM byte write enables
//   mem_addr_o  RAM byte address
//   mem_data_o  RAM write data
//   mem_data_i  RAM read data, valid the cycle after the read request
// ---------------------------------------------------------------------------
module ram_dma_copier #(
    parameter  int MEM_WIDTH = 65536,
    parameter  int LEN_W     = 16,
    localparam int AW        = $clog2(MEM_WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [AW-1:0]    src_i,
    input  logic [AW-1:0]    dst_i,
    input  logic [LEN_W-1:0] len_i,
`ifdef DMA_FILL_EN
    input  logic             fill_i,
    input  logic [31:0]      pattern_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             mem_en_o,
    output logic [3:0]       mem_we_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [31:0]      mem_data_o,
    input  logic [31:0]      mem_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_e;

    // The end-of-region sums are formed wide enough that they can never wrap.
    // Without this, a long transfer near the top of memory could wrap to a
    // small value and pass the range check.
    localparam int            CW        = AW + LEN_W + 2;
    localparam logic [CW-1:0] MEM_LIMIT = CW'(MEM_WIDTH);
    localparam logic [AW-1:0] WORD_STEP = AW'(4);

    state_e             state_q, state_d;
    logic [AW-1:0]      src_ptr_q, src_ptr_d;
    logic [AW-1:0]      dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic [31:0]        pattern_q, pattern_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_en_q, mem_en_d;
    logic [3:0]         mem_we_q, mem_we_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;

    // Fill-mode request. It is tied off when the fill feature is not built.
    logic               req_fill;
    logic [31:0]        req_pattern;
`ifdef DMA_FILL_EN
    assign req_fill    = fill_i;
    assign req_pattern = pattern_i;
`else
    assign req_fill    = 1'b0;
    assign req_pattern = 32'h0;
`endif

    // Start checks. These are evaluated combinationally on the request inputs.
    logic [CW-1:0] span;
    logic [CW-1:0] src_end;
    logic [CW-1:0] dst_end;
    logic          misaligned;
    logic          out_of_range;
    logic          start_bad;

    assign span         = CW'({len_i, 2'b00});
    assign src_end      = CW'(src_i) + span;
    assign dst_end      = CW'(dst_i) + span;
    assign misaligned   = (dst_i[1:0] != 2'b00) || (!req_fill && (src_i[1:0] != 2'b00));
    assign out_of_range = (dst_end > MEM_LIMIT) || (!req_fill && (src_end > MEM_LIMIT));
    assign start_bad    = misaligned || out_of_range;

    // Next-state and next-output logic. Each output register is loaded with
    // the value that belongs to the state being entered. This keeps the
    // registered outputs aligned with state_q.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. If a
        // path left one unassigned, synthesis would infer a latch.
        state_d    = state_q;
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        pattern_d  = pattern_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_en_d   = 1'b0;
        mem_we_d   = 4'h0;
        mem_addr_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_ptr_d = src_i;
                        dst_ptr_d = dst_i;
                        cnt_d     = len_i;
                        fill_d    = req_fill;
                        pattern_d = req_pattern;
                        busy_d    = 1'b1;
                        mem_en_d  = 1'b1;
                        if (req_fill) begin
                            state_d    = ST_WRITE;
                            mem_we_d   = 4'hF;
                            mem_addr_d = dst_i;
                        end else begin
                            state_d    = ST_READ;
                            mem_addr_d = src_i;
                        end
                    end
                end
            end

            ST_READ: begin
                state_d    = ST_WRITE;
                busy_d     = 1'b1;
                mem_en_d   = 1'b1;
                mem_we_d   = 4'hF;
                mem_addr_d = dst_ptr_q;
            end

            ST_WRITE: begin
                src_ptr_d = src_ptr_q + WORD_STEP;
                dst_ptr_d = dst_ptr_q + WORD_STEP;
                cnt_d     = cnt_q - LEN_W'(1);
                busy_d    = 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end else if (fill_q) begin
                    state_d    = ST_WRITE;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 4'hF;
                    mem_addr_d = dst_ptr_q + WORD_STEP;
                end else begin
                    state_d    = ST_READ;
                    mem_en_d   = 1'b1;
                    mem_addr_d = src_ptr_q + WORD_STEP;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Single state register for the FSM, the datapath and the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            cnt_q      <= '0;
            fill_q     <= 1'b0;
            pattern_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 4'h0;
            mem_addr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // register then samples the values from before this clock edge.
            state_q    <= state_d;
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            pattern_q  <= pattern_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // The RAM's registered read data is valid in the WRITE cycle, so it passes
    // straight through to the write port with no extra register stage.
    always_comb begin
        mem_data_o = '0;
        if (state_q == ST_WRITE) begin
            mem_data_o = fill_q ? pattern_q : mem_data_i;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign mem_en_o   = mem_en_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_ram_dma_copier.sv
// ---------------------------------------------------------------------------
// tb_ram_dma_copier
//
// Self-checking bench for ram_dma_copier. The bench contains a 64 KiB
// word-organised RAM with a registered read on the DUT's port.
//
// A reference memory array is updated with a plain forward word copy, or with
// a fill. It also produces the expected RAM access for each cycle from the
// transfer rules:
//   - copy: read word k in cycle 2k+1, write word k in cycle 2k+2;
//   - fill: write word k in cycle k+1;
//   - done_o two cycles after the last access.
//
// Define DMA_FILL_EN to also exercise fill mode.
// ---------------------------------------------------------------------------
module tb_ram_dma_copier;

    localparam int MW    = 65536;
    localparam int AW    = 16;
    localparam int LEN_W = 16;
    localparam int WORDS = MW / 4;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b1;
    logic             start_i = 1'b0;
    logic [AW-1:0]    src_i   = '0;
    logic [AW-1:0]    dst_i   = '0;
    logic [LEN_W-1:0] len_i   = '0;
`ifdef DMA_FILL_EN
    logic             fill_i    = 1'b0;
    logic [31:0]      pattern_i = '0;
`endif
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic             mem_en_o;
    logic [3:0]       mem_we_o;
    logic [AW-1:0]    mem_addr_o;
    logic [31:0]      mem_data_o;
    logic [31:0]      ram_rdata = '0;

    logic [31:0]      ram   [WORDS];
    logic [31:0]      model [WORDS];
    logic             load_req = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    ram_dma_copier #(.MEM_WIDTH(MW), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .src_i      (src_i),
        .dst_i      (dst_i),
        .len_i      (len_i),
`ifdef DMA_FILL_EN
        .fill_i     (fill_i),
        .pattern_i  (pattern_i),
`endif
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM: registered read, byte-enabled write. load_req copies the
    // reference array into the RAM in one step.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= model[i];
        end else if (mem_en_o) begin
            if (mem_we_o != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we_o[b]) ram[mem_addr_o[AW-1:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
            end else begin
                ram_rdata <= ram[mem_addr_o[AW-1:2]];
            end
        end
    end

    task automatic sync_ram();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic compare_mem(input string name);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int i = 0; i < WORDS; i++) begin
            if (ram[i] !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s mem: %0d words differ, first at 0x%04h got %08h exp %08h",
                     name, bad, first * 4, ram[first], model[first]);
            sync_ram();
        end
    endtask

    // Issue one start and check every following cycle. A nonzero retrig_cyc
    // re-asserts start_i with a misaligned source in that cycle; the DUT must
    // ignore it. A nonzero reset_cyc asserts reset_n=0 in that cycle.
    task automatic run_xfer(input string name, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input logic [LEN_W-1:0] len, input logic fill, input logic [31:0] pat,
                            input int retrig_cyc, input int reset_cyc);
        logic        bad;
        longint      s_end;
        longint      d_end;
        int          per;
        int          total;
        int          n_applied;
        logic [31:0] wq[$];
        logic [31:0] d;
        logic [7:0]  exp_ctl;
        logic [7:0]  got_ctl;
        logic [AW-1:0] exp_addr;
        logic [31:0] exp_data;
        logic        chk_data;
        logic        exp_busy, exp_done, exp_err, exp_en;
        logic [3:0]  exp_we;

        per   = fill ? 1 : 2;
        s_end = longint'(src) + 4 * longint'(len);
        d_end = longint'(dst) + 4 * longint'(len);
        bad   = (dst[1:0] != 2'b00) || (d_end > MW) ||
                (!fill && ((src[1:0] != 2'b00) || (s_end > MW)));
        total = (bad || len == 0) ? 2 : per * int'(len) + 3;

        n_applied = int'(len);
        if (reset_cyc > 0) begin
            n_applied = fill ? reset_cyc - 1 : (reset_cyc - 1) / 2;
            if (n_applied > int'(len)) n_applied = int'(len);
        end
        if (!bad) begin
            for (int k = 0; k < int'(len); k++) begin
                d = fill ? pat : model[(int'(src) >> 2) + k];
                wq.push_back(d);
                if (k < n_applied) model[(int'(dst) >> 2) + k] = d;
            end
        end

        @(negedge clk);
        src_i   = src;
        dst_i   = dst;
        len_i   = len;
`ifdef DMA_FILL_EN
        fill_i    = fill;
        pattern_i = pat;
`endif
        start_i = 1'b1;

        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            if (c == retrig_cyc) begin
                start_i = 1'b1;
                src_i   = 16'h0002;
                len_i   = 1;
            end else begin
                start_i = 1'b0;
            end

            if (c == reset_cyc) begin
                reset_n = 1'b0;
                #1;
                vectors++;
                if ({busy_o, done_o, err_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o} !== '0) begin
                    miscompares++;
                    $display("FAIL %s async reset: got busy=%b done=%b err=%b en=%b we=%h addr=%h data=%h exp all 0",
                             name, busy_o, done_o, err_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o);
                end
                for (int r = 0; r < 4; r++) begin
                    @(negedge clk);
                    if (r == 2) reset_n = 1'b1;
                    vectors++;
                    if ({busy_o, done_o, mem_en_o} !== 3'b000) begin
                        miscompares++;
                        $display("FAIL %s after reset %0d: got busy=%b done=%b en=%b exp 000",
                                 name, r, busy_o, done_o, mem_en_o);
                    end
                end
                break;
            end

            exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_en = 1'b0; exp_we = 4'h0;
            exp_addr = '0;  exp_data = '0;   chk_data = 1'b0;
            if (bad) begin
                exp_err = (c == 1);
            end else if (len == 0) begin
                exp_done = (c == 1);
            end else if (c <= per * int'(len)) begin
                exp_busy = 1'b1;
                exp_en   = 1'b1;
                if (fill) begin
                    exp_we   = 4'hF;
                    exp_addr = AW'(int'(dst) + 4 * (c - 1));
                    exp_data = wq[c-1];
                    chk_data = 1'b1;
                end else if (c % 2 == 1) begin
                    exp_addr = AW'(int'(src) + 4 * ((c - 1) / 2));
                end else begin
                    exp_we   = 4'hF;
                    exp_addr = AW'(int'(dst) + 4 * (c / 2 - 1));
                    exp_data = wq[c/2-1];
                    chk_data = 1'b1;
                end
            end else if (c == per * int'(len) + 1) begin
                exp_busy = 1'b1;
            end else if (c == per * int'(len) + 2) begin
                exp_done = 1'b1;
            end

            exp_ctl = {exp_busy, exp_done, exp_err, exp_en, exp_we};
            got_ctl = {busy_o, done_o, err_o, mem_en_o, mem_we_o};
            vectors++;
            if (got_ctl !== exp_ctl) begin
                miscompares++;
                $display("FAIL %s cycle %0d ctl{busy,done,err,en,we}: got %b exp %b", name, c, got_ctl, exp_ctl);
            end
            if (exp_en) begin
                vectors++;
                if (mem_addr_o !== exp_addr) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d addr: got %04h exp %04h", name, c, mem_addr_o, exp_addr);
                end
            end
            if (chk_data) begin
                vectors++;
                if (mem_data_o !== exp_data) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d wdata: got %08h exp %08h", name, c, mem_data_o, exp_data);
                end
            end
        end
        start_i = 1'b0;
        compare_mem(name);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy_o, done_o, err_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o} !== '0) begin
            miscompares++;
            $display("FAIL reset state: got busy=%b done=%b err=%b en=%b we=%h addr=%h data=%h exp all 0",
                     busy_o, done_o, err_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_copy();
        for (int i = 0; i < 4; i++) model[(32'h100 >> 2) + i] = 32'h11111111 * (i + 1);
        sync_ram();
        run_xfer("copy", 16'h0100, 16'h0200, 4, 1'b0, 32'h0, 0, 0);
    endtask

    task automatic test_zero_len();
        run_xfer("zero_len", 16'h0000, 16'h0004, 0, 1'b0, 32'h0, 0, 0);
    endtask

    task automatic test_errors();
        run_xfer("err_src_align", 16'h0102, 16'h0200, 1, 1'b0, 32'h0, 0, 0);
        run_xfer("err_dst_align", 16'h0100, 16'h0201, 1, 1'b0, 32'h0, 0, 0);
        run_xfer("err_dst_range", 16'h0100, 16'hFFFC, 2, 1'b0, 32'h0, 0, 0);
        run_xfer("err_src_range", 16'hFFF0, 16'h0400, 5, 1'b0, 32'h0, 0, 0);
        run_xfer("err_len_nowrap", 16'h0000, 16'h0400, 16'hFFFF, 1'b0, 32'h0, 0, 0);
        run_xfer("edge_dst_top", 16'h0100, 16'hFFF8, 2, 1'b0, 32'h0, 0, 0);
        run_xfer("edge_src_top", 16'hFFFC, 16'h0400, 1, 1'b0, 32'h0, 0, 0);
    endtask

    task automatic test_busy_reset();
        run_xfer("busy_ignore", 16'h0500, 16'h0600, 3, 1'b0, 32'h0, 2, 0);
        run_xfer("busy_reset", 16'h0500, 16'h0700, 8, 1'b0, 32'h0, 3, 5);
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 4; i++) model[i] = i + 1;
        sync_ram();
        run_xfer("overlap", 16'h0000, 16'h0004, 3, 1'b0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (ram[i] !== 32'h1) begin
                miscompares++;
                $display("FAIL overlap word %0d: got %08h exp 00000001", i, ram[i]);
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [AW-1:0]    s;
        logic [AW-1:0]    dd;
        logic [LEN_W-1:0] l;
        for (int n = 0; n < 30; n++) begin
            s  = AW'($urandom_range(0, 16'h3FF) * 4);
            dd = AW'($urandom_range(0, 16'h3FF) * 4);
            l  = LEN_W'($urandom_range(0, 12));
            if ($urandom_range(0, 5) == 0) s  = s  | AW'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) dd = AW'(MW - 4 * $urandom_range(1, 16));
            if ($urandom_range(0, 4) == 0) dd = s + AW'(4 * $urandom_range(1, 3));
`ifdef DMA_FILL_EN
            run_xfer("random", s, dd, l, 1'($urandom_range(0, 1)), $urandom, 0, 0);
`else
            run_xfer("random", s, dd, l, 1'b0, 32'h0, 0, 0);
`endif
        end
    endtask

`ifdef DMA_FILL_EN
    task automatic test_fill();
        run_xfer("fill", 16'h0103, 16'h0300, 3, 1'b1, 32'hDEADBEEF, 0, 0);
        run_xfer("fill_reset", 16'h0000, 16'h0340, 6, 1'b1, 32'hCAFEF00D, 0, 3);
        run_xfer("fill_err", 16'h0000, 16'hFFFC, 2, 1'b1, 32'h12345678, 0, 0);
    endtask
`endif

    initial begin
        for (int i = 0; i < WORDS; i++) model[i] = $urandom;
        test_reset();
        sync_ram();
        test_copy();
        test_zero_len();
        test_errors();
        test_busy_reset();
        test_overlap();
`ifdef DMA_FILL_EN
        test_fill();
`endif
        test_random_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
